serial_word_pair_transmitter_msb_first: RTL

//  Transmit side of the two-wire serial compare stream. Accepts a pair of

---
 rtl/serial_word_pair_transmitter_msb_first_if.sv | 25 ++
 rtl/serial_word_pair_transmitter_msb_first.sv | 103 ++++++++++
 2 files changed

// File: rtl/serial_word_pair_transmitter_msb_first_if.sv
// Word-pair handshake input and framed two-line serial output of the
// MSB-first word-pair transmitter.
interface serial_word_pair_transmitter_msb_first_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic             a;
    logic             b;

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, out_valid, out_first, out_last, a, b
    );

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, out_valid, out_first, out_last, a, b
    );
endinterface

// File: rtl/serial_word_pair_transmitter_msb_first.sv
// Serializes accepted (a, b) word pairs in lockstep, MSB first, one bit per
// clock, framing each word with first/last markers and optional idle gap.
module serial_word_pair_transmitter_msb_first #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    serial_word_pair_transmitter_msb_first_if.slave bus,
    output logic                                    busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sr_a, r_sr_b, w_sr_a_nxt, w_sr_b_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic             w_ready;
    logic             w_valid;
    logic             w_xfer;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sr_a    <= '0;
            r_sr_b    <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr_a    <= w_sr_a_nxt;
            r_sr_b    <= w_sr_b_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sr_a_nxt    = r_sr_a;
        w_sr_b_nxt    = r_sr_b;
        w_cnt_nxt     = r_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_ready       = 1'b0;
        w_valid       = 1'b0;
        w_xfer        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_SHIFT: begin
                w_valid = 1'b1;
                if (!w_cnt_zero) begin
                    w_sr_a_nxt = {r_sr_a[WIDTH-2:0], 1'b0};
                    w_sr_b_nxt = {r_sr_b[WIDTH-2:0], 1'b0};
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else if (GAP == 0) begin
                    // Back-to-back words: the LSB cycle doubles as the accept slot.
                    w_ready     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = GAP_W'(GAP);
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_xfer = bus.in_valid && w_ready;
        if (w_xfer) begin
            w_sr_a_nxt  = bus.in_a;
            w_sr_b_nxt  = bus.in_b;
            w_cnt_nxt   = CNT_W'(WIDTH - 1);
            w_state_nxt = ST_SHIFT;
        end
    end

    // Serial outputs are masked so nothing but zeros leaves outside a frame.
    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.a         = w_valid & r_sr_a[WIDTH-1];
    assign bus.b         = w_valid & r_sr_b[WIDTH-1];
    assign bus.out_first = w_valid && (r_cnt == CNT_W'(WIDTH - 1));
    assign bus.out_last  = w_valid && w_cnt_zero;
    assign busy          = (r_state != ST_IDLE);
endmodule
